// File: rtl/univ_reg_setres_pkg.sv
// Shared definitions for the universal register: operation codes and mode type.
package univ_reg_pkg;

  typedef logic [2:0] univ_mode_t;

  localparam univ_mode_t MODE_HOLD = 3'd0;
  localparam univ_mode_t MODE_LOAD = 3'd1;
  localparam univ_mode_t MODE_SHL  = 3'd2;
  localparam univ_mode_t MODE_SHR  = 3'd3;
  localparam univ_mode_t MODE_ROL  = 3'd4;
  localparam univ_mode_t MODE_ROR  = 3'd5;
  localparam univ_mode_t MODE_INC  = 3'd6;
  localparam univ_mode_t MODE_DEC  = 3'd7;

endpackage : univ_reg_pkg

// File: rtl/univ_reg_setres_if.sv
// Control/data bundle of the universal register.
// The master drives the controls and observes the register; the slave is the register.
interface univ_reg_setres_if #(
  parameter int WIDTH = 8
);
  import univ_reg_pkg::*;

  logic             clr;
  logic             set;
  logic             en;
  univ_mode_t       mode;
  logic [WIDTH-1:0] d;
  logic             sin_l;
  logic             sin_r;
  logic [WIDTH-1:0] q;
  logic             sout_l;
  logic             sout_r;
  logic             wrap;
  logic             zero;

  modport master (
    output clr, set, en, mode, d, sin_l, sin_r,
    input  q, sout_l, sout_r, wrap, zero
  );

  modport slave (
    input  clr, set, en, mode, d, sin_l, sin_r,
    output q, sout_l, sout_r, wrap, zero
  );

endinterface : univ_reg_setres_if

// File: rtl/univ_reg_setres_next.sv
// Combinational next-state function of the universal register for one mode
// operation, plus detection of an INC/DEC wrap-around.
module univ_reg_next
  import univ_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q_i,
  input  univ_mode_t       mode_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             sin_l_i,
  input  logic             sin_r_i,
  output logic [WIDTH-1:0] q_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  // Every 3-bit code is decoded explicitly; wrap only on INC/DEC overflow.
  always_comb begin
    q_o    = q_i;
    wrap_o = 1'b0;
    case (mode_i)
      MODE_HOLD: q_o = q_i;
      MODE_LOAD: q_o = d_i;
      MODE_SHL:  q_o = {q_i[WIDTH-2:0], sin_r_i};
      MODE_SHR:  q_o = {sin_l_i, q_i[WIDTH-1:1]};
      MODE_ROL:  q_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
      MODE_ROR:  q_o = {q_i[0], q_i[WIDTH-1:1]};
      MODE_INC: begin
        q_o    = q_i + ONE;
        wrap_o = (q_i == ALL_ONES);
      end
      MODE_DEC: begin
        q_o    = q_i - ONE;
        wrap_o = (q_i == '0);
      end
      default: begin
        q_o    = q_i;
        wrap_o = 1'b0;
      end
    endcase
  end

endmodule : univ_reg_next

// File: rtl/univ_reg_setres.sv
// Universal WIDTH-bit register: async active-low reset, sync clear/set,
// clock-enabled hold/load/shift/rotate/count, serial taps and a wrap pulse.
module univ_reg_setres
  import univ_reg_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter logic [WIDTH-1:0] SET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  univ_reg_setres_if.slave bus
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] op_q;
  logic             op_wrap;

  univ_reg_next #(.WIDTH(WIDTH)) u_next (
    .q_i     (q_q),
    .mode_i  (bus.mode),
    .d_i     (bus.d),
    .sin_l_i (bus.sin_l),
    .sin_r_i (bus.sin_r),
    .q_o     (op_q),
    .wrap_o  (op_wrap)
  );

  // Priority: clr over set over enabled mode op; wrap only survives an enabled op.
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (bus.clr) begin
      q_d = RST_VAL;
    end else if (bus.set) begin
      q_d = SET_VAL;
    end else if (bus.en) begin
      q_d    = op_q;
      wrap_d = op_wrap;
    end
  end

  // Storage: async reset aborts any in-flight operation immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= RST_VAL;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.q      = q_q;
  assign bus.wrap   = wrap_q;
  assign bus.sout_l = q_q[WIDTH-1];
  assign bus.sout_r = q_q[0];
  assign bus.zero   = (q_q == '0);

endmodule : univ_reg_setres

// File: tb/tb_univ_reg_setres.sv
// Directed checks of the 8-bit register plus a randomized reference-model
// comparison of 2-bit and 16-bit instances with non-default reset/set values.
module tb_univ_reg_setres;
  import univ_reg_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  univ_reg_setres_if #(.WIDTH(8))  b8 ();
  univ_reg_setres_if #(.WIDTH(2))  b2 ();
  univ_reg_setres_if #(.WIDTH(16)) b16 ();

  univ_reg_setres #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  univ_reg_setres #(.WIDTH(2), .RST_VAL(2'b10), .SET_VAL(2'b01))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  univ_reg_setres #(.WIDTH(16), .RST_VAL(16'hA5C3), .SET_VAL(16'h1234))
    dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        clr;
    logic        set;
    logic        en;
    logic [2:0]  mode;
    logic [15:0] d;
    logic        sl;
    logic        sr;
  } stim_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Apply one 8-bit transaction and advance one edge.
  task automatic op8(input logic clr, input logic set, input logic en, input logic [2:0] mode,
                     input logic [7:0] d, input logic sl, input logic sr);
    b8.clr = clr; b8.set = set; b8.en = en; b8.mode = mode;
    b8.d = d; b8.sin_l = sl; b8.sin_r = sr;
    step();
    $display("txn clr=%b set=%b en=%b mode=%0d d=%h -> q=%h wrap=%b", clr, set, en, mode, d,
             b8.q, b8.wrap);
  endtask

  // Independent arithmetic model of one edge for a width-w register.
  function automatic void ref_step(input int w, input logic [15:0] q, input logic [15:0] rv,
                                   input logic [15:0] sv, input stim_t s,
                                   output logic [15:0] nq, output logic nw);
    logic [15:0] mask;
    mask = 16'((32'd1 << w) - 1);
    nq = q;
    nw = 1'b0;
    if (s.clr) nq = rv;
    else if (s.set) nq = sv;
    else if (s.en) begin
      case (s.mode)
        3'd1: nq = s.d & mask;
        3'd2: nq = ((q << 1) | 16'(s.sr)) & mask;
        3'd3: nq = (16'(s.sl) << (w - 1)) | (q >> 1);
        3'd4: nq = ((q << 1) | (q >> (w - 1))) & mask;
        3'd5: nq = ((q & 16'd1) << (w - 1)) | (q >> 1);
        3'd6: begin nq = (q + 16'd1) & mask; nw = (q == mask); end
        3'd7: begin nq = (q - 16'd1) & mask; nw = (q == 16'd0); end
        default: nq = q;
      endcase
    end
  endfunction

  function automatic stim_t rnd_stim();
    stim_t s;
    s.clr  = ($urandom_range(15) == 0);
    s.set  = ($urandom_range(15) == 0);
    s.en   = ($urandom_range(3) != 0);
    s.mode = 3'($urandom_range(7));
    s.d    = 16'($urandom);
    s.sl   = 1'($urandom);
    s.sr   = 1'($urandom);
    return s;
  endfunction

  initial begin
    logic [15:0] m2, m16, n2, n16;
    logic        w2, w16;
    stim_t       s2, s16;

    b8.clr = 0;  b8.set = 0;  b8.en = 0;  b8.mode = MODE_HOLD;  b8.d = '0;  b8.sin_l = 0;  b8.sin_r = 0;
    b2.clr = 0;  b2.set = 0;  b2.en = 0;  b2.mode = MODE_HOLD;  b2.d = '0;  b2.sin_l = 0;  b2.sin_r = 0;
    b16.clr = 0; b16.set = 0; b16.en = 0; b16.mode = MODE_HOLD; b16.d = '0; b16.sin_l = 0; b16.sin_r = 0;

    // Async reset before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("rst_q", b8.q, 8'h00);
    check("rst_wrap", b8.wrap, 1'b0);
    check("rst_zero", b8.zero, 1'b1);
    check("rst_q2", b2.q, 2'b10);
    check("rst_q16", b16.q, 16'hA5C3);
    step();
    rst_n = 1'b1;

    // Shift in.
    op8(0, 0, 1, MODE_LOAD, 8'h81, 0, 0);
    check("load81", b8.q, 8'h81);
    check("sout_l_pre", b8.sout_l, 1'b1);
    check("sout_r_pre", b8.sout_r, 1'b1);
    op8(0, 0, 1, MODE_SHL, 8'h00, 0, 0);
    check("shl", b8.q, 8'h02);
    op8(0, 0, 1, MODE_SHR, 8'h00, 1, 0);
    check("shr", b8.q, 8'h81);

    // Rotate.
    op8(0, 0, 1, MODE_LOAD, 8'h96, 0, 0);
    op8(0, 0, 1, MODE_ROL, 8'h00, 0, 0);
    check("rol1", b8.q, 8'h2D);
    for (int i = 0; i < 7; i++) op8(0, 0, 1, MODE_ROL, 8'h00, 0, 0);
    check("rol8", b8.q, 8'h96);
    op8(0, 0, 1, MODE_ROR, 8'h00, 0, 0);
    check("ror1", b8.q, 8'h4B);

    // Counting and wrap pulses.
    op8(0, 0, 1, MODE_LOAD, 8'hFE, 0, 0);
    op8(0, 0, 1, MODE_INC, 8'h00, 0, 0);
    check("inc1_q", b8.q, 8'hFF);
    check("inc1_wrap", b8.wrap, 1'b0);
    op8(0, 0, 1, MODE_INC, 8'h00, 0, 0);
    check("inc2_q", b8.q, 8'h00);
    check("inc2_wrap", b8.wrap, 1'b1);
    check("inc2_zero", b8.zero, 1'b1);
    op8(0, 0, 1, MODE_DEC, 8'h00, 0, 0);
    check("dec_q", b8.q, 8'hFF);
    check("dec_wrap", b8.wrap, 1'b1);
    check("dec_zero", b8.zero, 1'b0);
    op8(0, 0, 1, MODE_HOLD, 8'h00, 0, 0);
    check("hold_q", b8.q, 8'hFF);
    check("hold_wrap", b8.wrap, 1'b0);

    // Priority and enable.
    op8(1, 1, 0, MODE_HOLD, 8'h00, 0, 0);
    check("clrset_q", b8.q, 8'h00);
    op8(0, 1, 0, MODE_HOLD, 8'h00, 0, 0);
    check("set_q", b8.q, 8'hFF);
    op8(0, 0, 0, MODE_LOAD, 8'h33, 0, 0);
    check("en0_q", b8.q, 8'hFF);
    op8(1, 0, 1, MODE_INC, 8'h00, 0, 0);
    check("clr_over_inc_q", b8.q, 8'h00);
    check("clr_over_inc_wrap", b8.wrap, 1'b0);
    op8(0, 1, 1, MODE_DEC, 8'h00, 0, 0);
    check("set_over_dec_q", b8.q, 8'hFF);
    check("set_over_dec_wrap", b8.wrap, 1'b0);

    // Async reset while a wrap pulse is showing.
    op8(0, 0, 1, MODE_INC, 8'h00, 0, 0);
    check("pre_rst_wrap", b8.wrap, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_wrap", b8.wrap, 1'b0);
    check("arst_q0", b8.q, 8'h00);
    rst_n = 1'b1;

    // Async reset mid-INC from 8'h5A, no clock edge needed.
    op8(0, 0, 1, MODE_LOAD, 8'h5A, 0, 0);
    check("load5a", b8.q, 8'h5A);
    b8.mode = MODE_INC;
    #2 rst_n = 1'b0;
    #1;
    check("midinc_q", b8.q, 8'h00);
    check("midinc_wrap", b8.wrap, 1'b0);
    step();
    check("rst_hold_q", b8.q, 8'h00);
    rst_n = 1'b1;
    op8(0, 0, 1, MODE_INC, 8'h00, 0, 0);
    check("post_rel_inc", b8.q, 8'h01);
    b8.en = 0;

    // Randomized sweep of the 2-bit and 16-bit instances.
    m2  = 16'h0002;
    m16 = 16'hA5C3;
    check("sweep_start2", b2.q, m2[1:0]);
    check("sweep_start16", b16.q, m16);
    for (int i = 0; i < 10000; i++) begin
      s2  = rnd_stim();
      s16 = rnd_stim();
      b2.clr = s2.clr; b2.set = s2.set; b2.en = s2.en; b2.mode = s2.mode;
      b2.d = s2.d[1:0]; b2.sin_l = s2.sl; b2.sin_r = s2.sr;
      b16.clr = s16.clr; b16.set = s16.set; b16.en = s16.en; b16.mode = s16.mode;
      b16.d = s16.d; b16.sin_l = s16.sl; b16.sin_r = s16.sr;
      ref_step(2, m2, 16'h0002, 16'h0001, s2, n2, w2);
      ref_step(16, m16, 16'hA5C3, 16'h1234, s16, n16, w16);
      step();
      check("w2_q", b2.q, n2);
      check("w2_wrap", b2.wrap, w2);
      check("w2_zero", b2.zero, (n2 == 16'd0));
      check("w2_sout", {b2.sout_l, b2.sout_r}, n2[1:0]);
      check("w16_q", b16.q, n16);
      check("w16_wrap", b16.wrap, w16);
      check("w16_zero", b16.zero, (n16 == 16'd0));
      check("w16_sout", {b16.sout_l, b16.sout_r}, {n16[15], n16[0]});
      m2  = n2;
      m16 = n16;
    end
    $display("sweep done: %0d cycles on WIDTH=2 and WIDTH=16", 10000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_univ_reg_setres
